// File: rtl/tag_gen_pkg.sv
// Shared constants, register map and types for the synthetic tag stream generator.
package tag_gen_pkg;

  localparam int unsigned WORD_WIDTH    = 4;
  localparam int unsigned TIME_WIDTH    = 64;
  localparam int unsigned CHANNEL_WIDTH = 6;
  localparam int unsigned WB_AW         = 8;
  localparam int unsigned WB_DW         = 32;

  localparam logic [WB_AW-1:0] ADDR_CTRL     = 8'h00;
  localparam logic [WB_AW-1:0] ADDR_PERIOD   = 8'h04;
  localparam logic [WB_AW-1:0] ADDR_CHANNELS = 8'h08;
  localparam logic [WB_AW-1:0] ADDR_BEATS    = 8'h0C;
  localparam logic [WB_AW-1:0] ADDR_KEEP     = 8'h10;
  localparam logic [WB_AW-1:0] ADDR_SENT     = 8'h14;
  localparam logic [WB_AW-1:0] ADDR_STATUS   = 8'h18;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT  = 1;
  localparam int unsigned CH_B_LSB        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [WB_DW-1:0]         period;
    logic [CHANNEL_WIDTH-1:0] ch_b;
    logic [CHANNEL_WIDTH-1:0] ch_a;
    logic [WB_DW-1:0]         beats;
    logic [WORD_WIDTH-1:0]    keep;
  } tag_cfg_t;

  // A programmed period of zero behaves as one picosecond.
  function automatic logic [TIME_WIDTH-1:0] eff_period(input logic [WB_DW-1:0] p);
    return (p == '0) ? TIME_WIDTH'(1) : TIME_WIDTH'(p);
  endfunction

endpackage

// File: rtl/tag_stream_generator_if.sv
// Tag AXI-stream and Wishbone classic bundles used by the tag stream generator.
interface tag_axis_if;
  import tag_gen_pkg::*;
  logic                                m_tvalid;
  logic                                m_tready;
  logic [WORD_WIDTH-1:0]               m_tkeep;
  logic [TIME_WIDTH*WORD_WIDTH-1:0]    m_tagtime;
  logic [CHANNEL_WIDTH*WORD_WIDTH-1:0] m_channel;
  logic [TIME_WIDTH-1:0]               m_lowest_time_bound;

  modport master (output m_tvalid, m_tkeep, m_tagtime, m_channel, m_lowest_time_bound,
                  input  m_tready);
  modport slave  (input  m_tvalid, m_tkeep, m_tagtime, m_channel, m_lowest_time_bound,
                  output m_tready);
endinterface

interface tag_wb_if;
  import tag_gen_pkg::*;
  logic             wb_cyc;
  logic             wb_stb;
  logic             wb_we;
  logic [WB_AW-1:0] wb_adr;
  logic [WB_DW-1:0] wb_dat_i;
  logic [WB_DW-1:0] wb_dat_o;
  logic             wb_ack;

  modport master (output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i, input wb_dat_o, wb_ack);
  modport slave  (input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i, output wb_dat_o, wb_ack);
endinterface

// File: rtl/tag_gen_wb_regs.sv
// Wishbone register block: live configuration, start/stop pulses, SENT counter and readback.
module tag_gen_wb_regs
  import tag_gen_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  tag_wb_if.slave  wb,
  input  logic     busy,
  input  logic     accept,
  output tag_cfg_t cfg,
  output logic     start_pulse,
  output logic     stop_pulse
);

  logic             ack_q, ack_d;
  logic [WB_DW-1:0] dat_q, dat_d;
  tag_cfg_t         cfg_q, cfg_d;
  logic             en_q, en_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic [WB_DW-1:0] sent_q, sent_d;
  logic             req_c, wr_c, rd_c;
  logic [WB_DW-1:0] rd_data_c;

  always_comb begin : rd_mux
    req_c     = wb.wb_cyc & wb.wb_stb & ~ack_q;
    wr_c      = req_c & wb.wb_we;
    rd_c      = req_c & ~wb.wb_we;
    rd_data_c = '0;
    case (wb.wb_adr)
      ADDR_CTRL:     rd_data_c[CTRL_ENABLE_BIT] = en_q;
      ADDR_PERIOD:   rd_data_c = cfg_q.period;
      ADDR_CHANNELS: begin
        rd_data_c[CHANNEL_WIDTH-1:0]         = cfg_q.ch_a;
        rd_data_c[CH_B_LSB +: CHANNEL_WIDTH] = cfg_q.ch_b;
      end
      ADDR_BEATS:    rd_data_c = cfg_q.beats;
      ADDR_KEEP:     rd_data_c[WORD_WIDTH-1:0] = cfg_q.keep;
      ADDR_SENT:     rd_data_c = sent_q;
      ADDR_STATUS:   rd_data_c[0] = busy;
      default:       rd_data_c = '0;
    endcase
  end

  // Clear wins over a coincident accept; the counter sticks at all-ones.
  always_comb begin : reg_next
    ack_d   = req_c;
    dat_d   = rd_c ? rd_data_c : '0;
    cfg_d   = cfg_q;
    en_d    = en_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    sent_d  = sent_q;
    if (accept && (sent_q != '1)) sent_d = sent_q + 32'd1;
    if (wr_c) begin
      case (wb.wb_adr)
        ADDR_CTRL: begin
          en_d    = wb.wb_dat_i[CTRL_ENABLE_BIT];
          start_d = wb.wb_dat_i[CTRL_ENABLE_BIT];
          stop_d  = ~wb.wb_dat_i[CTRL_ENABLE_BIT];
          if (wb.wb_dat_i[CTRL_CLEAR_BIT]) sent_d = '0;
        end
        ADDR_PERIOD:   cfg_d.period = wb.wb_dat_i;
        ADDR_CHANNELS: begin
          cfg_d.ch_a = wb.wb_dat_i[CHANNEL_WIDTH-1:0];
          cfg_d.ch_b = wb.wb_dat_i[CH_B_LSB +: CHANNEL_WIDTH];
        end
        ADDR_BEATS:    cfg_d.beats = wb.wb_dat_i;
        ADDR_KEEP:     cfg_d.keep  = wb.wb_dat_i[WORD_WIDTH-1:0];
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      cfg_q   <= '0;
      en_q    <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      sent_q  <= '0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      cfg_q   <= cfg_d;
      en_q    <= en_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      sent_q  <= sent_d;
    end
  end

  assign wb.wb_ack    = ack_q;
  assign wb.wb_dat_o  = dat_q;
  assign cfg          = cfg_q;
  assign start_pulse  = start_q;
  assign stop_pulse   = stop_q;

endmodule

// File: rtl/tag_stream_generator.sv
// Synthetic time-tag source: shadow config, run/drain FSM and registered tag beat datapath.
module tag_stream_generator
  import tag_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  tag_axis_if.master m_axis,
  tag_wb_if.slave    wb
);

  tag_cfg_t                            cfg, sh_q, sh_d, use_c;
  logic                                start_pulse, stop_pulse;
  state_e                              state_q, state_d;
  logic [TIME_WIDTH-1:0]               t_q, t_d, step_c;
  logic [WB_DW-1:0]                    cnt_q, cnt_d, gidx_c;
  logic                                tvalid_q, tvalid_d;
  logic [WORD_WIDTH-1:0]               tkeep_q, tkeep_d;
  logic [TIME_WIDTH*WORD_WIDTH-1:0]    tagtime_q, tagtime_d;
  logic [CHANNEL_WIDTH*WORD_WIDTH-1:0] channel_q, channel_d;
  logic [TIME_WIDTH-1:0]               bound_q, bound_d;
  logic                                accept_c, last_c, present_c;

  assign accept_c = tvalid_q & m_axis.m_tready;
  assign last_c   = (sh_q.beats != '0) && (32'(cnt_q + 32'd1) == sh_q.beats);

  tag_gen_wb_regs u_regs (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb),
    .busy        (state_q != ST_IDLE),
    .accept      (accept_c),
    .cfg         (cfg),
    .start_pulse (start_pulse),
    .stop_pulse  (stop_pulse)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_pulse) state_d = ST_RUN;
      ST_RUN: begin
        if (accept_c && last_c)  state_d = ST_IDLE;
        else if (stop_pulse)     state_d = accept_c ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: if (accept_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next beat is built ahead of time so every stream output leaves a flop.
  always_comb begin : fsm_out
    sh_d      = sh_q;
    t_d       = t_q;
    cnt_d     = cnt_q;
    tvalid_d  = tvalid_q;
    tkeep_d   = tkeep_q;
    tagtime_d = tagtime_q;
    channel_d = channel_q;
    bound_d   = bound_q;
    use_c     = sh_q;
    present_c = 1'b0;
    step_c    = '0;
    gidx_c    = '0;
    if ((state_q == ST_IDLE) && start_pulse) begin
      sh_d      = cfg;
      use_c     = cfg;
      t_d       = '0;
      cnt_d     = '0;
      present_c = 1'b1;
    end else if (accept_c) begin
      t_d       = t_q + TIME_WIDTH'(WORD_WIDTH) * eff_period(sh_q.period);
      cnt_d     = cnt_q + 32'd1;
      tvalid_d  = 1'b0;
      present_c = (state_d == ST_RUN);
    end
    if (present_c) begin
      step_c   = eff_period(use_c.period);
      tvalid_d = 1'b1;
      tkeep_d  = use_c.keep;
      bound_d  = t_d;
      for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
        tagtime_d[i*TIME_WIDTH +: TIME_WIDTH] = t_d + TIME_WIDTH'(i) * step_c;
        gidx_c = cnt_d * 32'(WORD_WIDTH) + 32'(i);
        channel_d[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] = gidx_c[0] ? use_c.ch_b : use_c.ch_a;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q      <= '0;
      t_q       <= '0;
      cnt_q     <= '0;
      tvalid_q  <= 1'b0;
      tkeep_q   <= '0;
      tagtime_q <= '0;
      channel_q <= '0;
      bound_q   <= '0;
    end else begin
      sh_q      <= sh_d;
      t_q       <= t_d;
      cnt_q     <= cnt_d;
      tvalid_q  <= tvalid_d;
      tkeep_q   <= tkeep_d;
      tagtime_q <= tagtime_d;
      channel_q <= channel_d;
      bound_q   <= bound_d;
    end
  end

  assign m_axis.m_tvalid            = tvalid_q;
  assign m_axis.m_tkeep             = tkeep_q;
  assign m_axis.m_tagtime           = tagtime_q;
  assign m_axis.m_channel           = channel_q;
  assign m_axis.m_lowest_time_bound = bound_q;

endmodule

// File: tb/tb_tag_stream_generator.sv
// Directed bench for tag_stream_generator with hand-computed beat contents.
module tb_tag_stream_generator;
  import tag_gen_pkg::*;

  logic clk = 1'b0;
  logic rst;
  tag_axis_if axis ();
  tag_wb_if   wb ();

  tag_stream_generator dut (
    .clk    (clk),
    .rst    (rst),
    .m_axis (axis),
    .wb     (wb)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned acc_cnt  = 0;
  int unsigned acc0;
  logic [31:0] rd;

  always @(posedge clk) if (rst && axis.m_tvalid && axis.m_tready) acc_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [7:0] a, input logic [31:0] wd,
                         output logic [31:0] rdat);
    bit got = 0;
    rdat = '0;
    @(negedge clk);
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = we; wb.wb_adr = a; wb.wb_dat_i = wd;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk); #1;
      if (wb.wb_ack) begin
        got  = 1;
        rdat = wb.wb_dat_o;
      end
    end
    if (!got) check_eq("wb_ack_timeout", 64'd0, 64'd1);
    @(negedge clk);
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, dummy);
  endtask

  task automatic wb_read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    wb_xfer(1'b0, a, 32'd0, v);
    check_eq(tag, 64'(v), 64'(exp));
  endtask

  task automatic check_beat(input string tag, input logic [63:0] base, input logic [63:0] step,
                            input logic [5:0] ca, input logic [5:0] cb, input logic [3:0] keep);
    check_eq({tag, "_valid"}, 64'(axis.m_tvalid), 64'd1);
    check_eq({tag, "_keep"},  64'(axis.m_tkeep), 64'(keep));
    check_eq({tag, "_bound"}, axis.m_lowest_time_bound, base);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_time%0d", tag, i), axis.m_tagtime[i*64 +: 64], base + 64'(i) * step);
      check_eq($sformatf("%s_ch%0d", tag, i), 64'(axis.m_channel[i*6 +: 6]),
               (i % 2 == 1) ? 64'(cb) : 64'(ca));
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(axis.m_tvalid), 64'd0);
    check_eq({tag, "_keep"},  64'(axis.m_tkeep), 64'd0);
    check_eq({tag, "_bound"}, axis.m_lowest_time_bound, 64'd0);
    check_eq({tag, "_chan"},  64'(axis.m_channel), 64'd0);
    check_eq({tag, "_ack"},   64'(wb.wb_ack), 64'd0);
    check_eq({tag, "_dato"},  64'(wb.wb_dat_o), 64'd0);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("%s_time%0d", tag, i), axis.m_tagtime[i*64 +: 64], 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    axis.m_tready = 1'b0;
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0; wb.wb_adr = '0; wb.wb_dat_i = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // Two-beat run with ready held high.
    axis.m_tready = 1'b1;
    wb_write(ADDR_PERIOD, 32'd10);
    wb_write(ADDR_CHANNELS, 32'h0000_0201);
    wb_write(ADDR_BEATS, 32'd2);
    wb_write(ADDR_KEEP, 32'hF);
    wb_write(ADDR_CTRL, 32'h1);
    check_eq("t1_prevalid", 64'(axis.m_tvalid), 64'd0);
    @(negedge clk); check_beat("t1_b0", 64'd0, 64'd10, 6'd1, 6'd2, 4'hF);
    @(negedge clk); check_beat("t1_b1", 64'd40, 64'd10, 6'd1, 6'd2, 4'hF);
    @(negedge clk); check_eq("t1_done_valid", 64'(axis.m_tvalid), 64'd0);
    wb_read_check("t1_sent", ADDR_SENT, 32'd2);
    wb_read_check("t1_busy", ADDR_STATUS, 32'd0);

    // Back-pressure pattern 1-0-0-1.
    axis.m_tready = 1'b0;
    wb_write(ADDR_CTRL, 32'h2);
    wb_read_check("t2_cleared", ADDR_SENT, 32'd0);
    acc0 = acc_cnt;
    wb_write(ADDR_CTRL, 32'h1);
    @(negedge clk); check_beat("t2_b0", 64'd0, 64'd10, 6'd1, 6'd2, 4'hF); axis.m_tready = 1'b1;
    @(negedge clk); check_beat("t2_b1", 64'd40, 64'd10, 6'd1, 6'd2, 4'hF); axis.m_tready = 1'b0;
    @(negedge clk); check_beat("t2_hold1", 64'd40, 64'd10, 6'd1, 6'd2, 4'hF);
    @(negedge clk); check_beat("t2_hold2", 64'd40, 64'd10, 6'd1, 6'd2, 4'hF); axis.m_tready = 1'b1;
    @(negedge clk); check_eq("t2_done_valid", 64'(axis.m_tvalid), 64'd0);
    check_eq("t2_accepts", 64'(acc_cnt - acc0), 64'd2);
    wb_read_check("t2_sent", ADDR_SENT, 32'd2);

    // Unlimited run, then drain a held beat.
    wb_write(ADDR_CTRL, 32'h2);
    wb_write(ADDR_BEATS, 32'd0);
    wb_write(ADDR_CTRL, 32'h1);
    @(negedge clk); check_beat("t3_b0", 64'd0, 64'd10, 6'd1, 6'd2, 4'hF);
    repeat (5) @(negedge clk);
    axis.m_tready = 1'b0;
    check_beat("t3_b5", 64'd200, 64'd10, 6'd1, 6'd2, 4'hF);
    wb_read_check("t3_sent5", ADDR_SENT, 32'd5);
    wb_write(ADDR_CTRL, 32'h0);
    @(negedge clk); check_beat("t3_drain", 64'd200, 64'd10, 6'd1, 6'd2, 4'hF);
    wb_read_check("t3_busy_drain", ADDR_STATUS, 32'd1);
    axis.m_tready = 1'b1;
    @(negedge clk); check_eq("t3_done_valid", 64'(axis.m_tvalid), 64'd0);
    wb_read_check("t3_sent6", ADDR_SENT, 32'd6);
    wb_read_check("t3_idle", ADDR_STATUS, 32'd0);

    // Zero period acts as one picosecond.
    axis.m_tready = 1'b0;
    wb_write(ADDR_PERIOD, 32'd0);
    wb_write(ADDR_CHANNELS, 32'h0000_0403);
    wb_write(ADDR_BEATS, 32'd1);
    wb_write(ADDR_KEEP, 32'h5);
    wb_write(ADDR_CTRL, 32'h1);
    @(negedge clk); check_beat("t4_b0", 64'd0, 64'd1, 6'd3, 6'd4, 4'h5); axis.m_tready = 1'b1;
    @(negedge clk); check_eq("t4_done_valid", 64'(axis.m_tvalid), 64'd0);

    // Live PERIOD write during a run does not disturb the shadow copy.
    axis.m_tready = 1'b0;
    wb_write(ADDR_PERIOD, 32'd10);
    wb_write(ADDR_CHANNELS, 32'h0000_0201);
    wb_write(ADDR_BEATS, 32'd3);
    wb_write(ADDR_KEEP, 32'hF);
    wb_write(ADDR_CTRL, 32'h1);
    @(negedge clk); check_beat("t5_b0", 64'd0, 64'd10, 6'd1, 6'd2, 4'hF);
    wb_write(ADDR_PERIOD, 32'd100);
    wb_read_check("t5_live_period", ADDR_PERIOD, 32'd100);
    axis.m_tready = 1'b1;
    @(negedge clk); check_beat("t5_b1_old", 64'd40, 64'd10, 6'd1, 6'd2, 4'hF);
    @(negedge clk); check_beat("t5_b2_old", 64'd80, 64'd10, 6'd1, 6'd2, 4'hF);
    @(negedge clk); check_eq("t5_done_valid", 64'(axis.m_tvalid), 64'd0);
    axis.m_tready = 1'b0;
    wb_write(ADDR_CTRL, 32'h1);
    @(negedge clk); check_beat("t5_b0_new", 64'd0, 64'd100, 6'd1, 6'd2, 4'hF); axis.m_tready = 1'b1;
    @(negedge clk); check_beat("t5_b1_new", 64'd400, 64'd100, 6'd1, 6'd2, 4'hF);
    @(negedge clk); check_beat("t5_b2_new", 64'd800, 64'd100, 6'd1, 6'd2, 4'hF);
    @(negedge clk); check_eq("t5_done2_valid", 64'(axis.m_tvalid), 64'd0);

    // Unmapped address: write ignored, reads zero.
    wb_write(8'h1C, 32'hFFFF_FFFF);
    wb_read_check("unmapped", 8'h1C, 32'd0);

    // Reset in the middle of a held beat.
    axis.m_tready = 1'b0;
    wb_write(ADDR_CTRL, 32'h1);
    @(negedge clk); check_eq("t6_prereset_valid", 64'(axis.m_tvalid), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero("t6_reset");
    @(negedge clk); rst = 1'b1;
    wb_read_check("t6_sent", ADDR_SENT, 32'd0);
    wb_read_check("t6_status", ADDR_STATUS, 32'd0);
    wb_read_check("t6_period", ADDR_PERIOD, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
